pu_layer_sequencer: RTL and testbench

Parametrised successor to the PU top-level controller. Sequences a convolution run over a runtime-selected number of layers. For each layer it fetches the layer's tile count from the config store, then issues tiles to the PE array one at a time using a start/done handshake. It sits between the host start/abort control and the PU compute datapath.

---
 rtl/pu_layer_sequencer_pkg.sv | 16 +
 rtl/pu_layer_sequencer_loop_counter.sv | 35 +++
 rtl/pu_layer_sequencer.sv | 146 ++++++++++++++
 tb/tb_pu_layer_sequencer.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pu_layer_sequencer_pkg.sv
// Shared state encoding and defaults for the PU layer sequencer.
package pu_layer_sequencer_pkg;

  localparam int STATE_WIDTH = 3;
  localparam int PU_MAX_LAYERS = 8;

  typedef enum logic [STATE_WIDTH-1:0] {
    S_IDLE  = 3'd0,
    S_CFG   = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_NEXT  = 3'd4,
    S_DONE  = 3'd5
  } pu_state_e;

endpackage

// File: rtl/pu_layer_sequencer_loop_counter.sv
// Clear/increment loop counter with a terminal-match flag.
module pu_loop_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] term,
  output logic [W-1:0] cnt,
  output logic         at_term
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (inc)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
  assign at_term = (cnt_q == term);

endmodule

// File: rtl/pu_layer_sequencer.sv
// Layer/tile run sequencer between host control and the PE array.
module pu_layer_sequencer
  import pu_layer_sequencer_pkg::*;
#(
  parameter int LAYER_PARAM_WIDTH = 10,
  parameter int TILE_CNT_WIDTH = 16,
  parameter int MAX_LAYERS = PU_MAX_LAYERS
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         abort,
  input  logic [LAYER_PARAM_WIDTH-1:0] num_layers,
  output logic                         cfg_req,
  output logic [LAYER_PARAM_WIDTH-1:0] cfg_layer,
  input  logic                         cfg_valid,
  input  logic [TILE_CNT_WIDTH-1:0]    cfg_num_tiles,
  output logic                         tile_start,
  output logic [TILE_CNT_WIDTH-1:0]    tile_idx,
  input  logic                         tile_done,
  output logic [LAYER_PARAM_WIDTH-1:0] layer_idx,
  output logic [STATE_WIDTH-1:0]       state,
  output logic                         busy,
  output logic                         done
);

  localparam logic [LAYER_PARAM_WIDTH-1:0] MAX_L =
    LAYER_PARAM_WIDTH'(MAX_LAYERS);

  pu_state_e state_q, state_d;
  logic [LAYER_PARAM_WIDTH-1:0] layers_lat_q, layers_lat_d;
  logic [TILE_CNT_WIDTH-1:0]    tiles_lat_q, tiles_lat_d;
  logic zero_done_q, zero_done_d;

  logic t_clr, t_inc, t_last;
  logic l_clr, l_inc, l_last;

  pu_loop_counter #(.W(TILE_CNT_WIDTH)) u_tile_cnt (
    .clk     (clk),
    .rst_n   (reset),
    .clr     (t_clr),
    .inc     (t_inc),
    .term    (tiles_lat_q - 1'b1),
    .cnt     (tile_idx),
    .at_term (t_last)
  );

  pu_loop_counter #(.W(LAYER_PARAM_WIDTH)) u_layer_cnt (
    .clk     (clk),
    .rst_n   (reset),
    .clr     (l_clr),
    .inc     (l_inc),
    .term    (layers_lat_q - 1'b1),
    .cnt     (layer_idx),
    .at_term (l_last)
  );

  always_comb begin
    state_d      = state_q;
    layers_lat_d = layers_lat_q;
    tiles_lat_d  = tiles_lat_q;
    zero_done_d  = 1'b0;
    t_clr = 1'b0;
    t_inc = 1'b0;
    l_clr = 1'b0;
    l_inc = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (num_layers == '0) begin
            zero_done_d = 1'b1;
          end else begin
            layers_lat_d = (num_layers > MAX_L) ? MAX_L : num_layers;
            t_clr   = 1'b1;
            l_clr   = 1'b1;
            state_d = S_CFG;
          end
        end
      end
      S_CFG: begin
        if (cfg_valid) begin
          tiles_lat_d = cfg_num_tiles;
          state_d = (cfg_num_tiles == '0) ? S_NEXT : S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (tile_done) begin
          if (t_last) begin
            state_d = S_NEXT;
          end else begin
            t_inc   = 1'b1;
            state_d = S_ISSUE;
          end
        end
      end
      S_NEXT: begin
        if (l_last) begin
          state_d = S_DONE;
        end else begin
          l_inc   = 1'b1;
          t_clr   = 1'b1;
          state_d = S_CFG;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: begin
        t_clr   = 1'b1;
        l_clr   = 1'b1;
        state_d = S_IDLE;
      end
    endcase
    // Abort wins over any transition chosen above.
    if (abort && state_q != S_IDLE) begin
      state_d      = S_IDLE;
      layers_lat_d = '0;
      tiles_lat_d  = '0;
      t_clr = 1'b1;
      t_inc = 1'b0;
      l_clr = 1'b1;
      l_inc = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      layers_lat_q <= '0;
      tiles_lat_q  <= '0;
      zero_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      layers_lat_q <= layers_lat_d;
      tiles_lat_q  <= tiles_lat_d;
      zero_done_q  <= zero_done_d;
    end
  end

  assign state      = state_q;
  assign busy       = (state_q != S_IDLE);
  assign cfg_req    = (state_q == S_CFG);
  assign cfg_layer  = layer_idx;
  assign tile_start = (state_q == S_ISSUE);
  assign done       = (state_q == S_DONE) | zero_done_q;

endmodule

// File: tb/tb_pu_layer_sequencer.sv
// Directed-vector bench for pu_layer_sequencer.
module tb_pu_layer_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        abort;
  logic [9:0]  num_layers;
  logic        cfg_req;
  logic [9:0]  cfg_layer;
  logic        cfg_valid;
  logic [15:0] cfg_num_tiles;
  logic        tile_start;
  logic [15:0] tile_idx;
  logic        tile_done;
  logic [9:0]  layer_idx;
  logic [2:0]  state;
  logic        busy;
  logic        done;

  pu_layer_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .abort         (abort),
    .num_layers    (num_layers),
    .cfg_req       (cfg_req),
    .cfg_layer     (cfg_layer),
    .cfg_valid     (cfg_valid),
    .cfg_num_tiles (cfg_num_tiles),
    .tile_start    (tile_start),
    .tile_idx      (tile_idx),
    .tile_done     (tile_done),
    .layer_idx     (layer_idx),
    .state         (state),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  int tiles_tab [0:31];
  int log_q [$];
  int done_cnt, cfg_phases, last_cfg_layer, first_cfg_layer;
  int done_cyc, busy_hi;
  bit aborted;
  int post_state, post_busy, post_layer, post_tile;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic run(input int nl, input int max_cyc, input bit do_abort);
    int cd;
    bit prev_req;
    log_q.delete();
    done_cnt = 0;
    cfg_phases = 0;
    last_cfg_layer = -1;
    first_cfg_layer = -1;
    done_cyc = -1;
    busy_hi = 0;
    aborted = 0;
    cd = 0;
    prev_req = 0;
    @(negedge clk);
    start = 1'b1;
    num_layers = 10'(nl);
    for (int cyc = 1; cyc <= max_cyc; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      tile_done = 1'b0;
      if (busy) busy_hi++;
      if (cfg_req && !prev_req) begin
        cfg_phases++;
        last_cfg_layer = int'(cfg_layer);
        if (first_cfg_layer < 0) first_cfg_layer = int'(cfg_layer);
      end
      prev_req = cfg_req;
      cfg_valid = cfg_req;
      cfg_num_tiles = 16'(tiles_tab[cfg_layer[4:0]]);
      if (cd > 0) begin
        cd--;
        if (cd == 0) tile_done = 1'b1;
      end
      if (tile_start) begin
        log_q.push_back(int'(layer_idx) * 256 + int'(tile_idx));
        cd = 2;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        break;
      end
      if (do_abort && state == 3'd3 && layer_idx == 10'd1 &&
          tile_idx == 16'd2) begin
        abort = 1'b1;
        tile_done = 1'b1;
        aborted = 1;
        break;
      end
    end
    @(negedge clk);
    abort = 1'b0;
    cfg_valid = 1'b0;
    tile_done = 1'b0;
    post_state = int'(state);
    post_busy = int'(busy);
    post_layer = int'(layer_idx);
    post_tile = int'(tile_idx);
    if (done) done_cnt++;
    repeat (4) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
  endtask

  initial begin
    int lyr1;
    reset = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    num_layers = '0;
    cfg_valid = 1'b0;
    cfg_num_tiles = '0;
    tile_done = 1'b0;
    for (int i = 0; i < 32; i++) tiles_tab[i] = 1;
    repeat (2) @(negedge clk);
    chk("rst_state", int'(state), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_cfg_req", int'(cfg_req), 0);
    chk("rst_tile_start", int'(tile_start), 0);
    reset = 1'b1;
    @(negedge clk);

    // two layers: 3 tiles then 1 tile
    tiles_tab[0] = 3;
    tiles_tab[1] = 1;
    run(2, 200, 0);
    chk("t1_ntiles", log_q.size(), 4);
    if (log_q.size() == 4) begin
      chk("t1_tile0", log_q[0], 0);
      chk("t1_tile1", log_q[1], 1);
      chk("t1_tile2", log_q[2], 2);
      chk("t1_tile3", log_q[3], 256);
    end
    chk("t1_done_cnt", done_cnt, 1);
    chk("t1_done_cyc", done_cyc, 17);
    chk("t1_cfg_phases", cfg_phases, 2);
    chk("t1_post_busy", post_busy, 0);
    chk("t1_post_state", post_state, 0);
    chk("t1_hold_layer", post_layer, 1);

    // zero layers
    run(0, 50, 0);
    chk("t2_done_cyc", done_cyc, 1);
    chk("t2_done_cnt", done_cnt, 1);
    chk("t2_busy", busy_hi, 0);
    chk("t2_cfg", cfg_phases, 0);

    // middle layer has no tiles
    tiles_tab[0] = 2;
    tiles_tab[1] = 0;
    tiles_tab[2] = 1;
    run(3, 200, 0);
    lyr1 = 0;
    foreach (log_q[i]) if (log_q[i] / 256 == 1) lyr1++;
    chk("t3_ntiles", log_q.size(), 3);
    chk("t3_layer1_tiles", lyr1, 0);
    if (log_q.size() == 3) chk("t3_last_tile", log_q[2], 512);
    chk("t3_cfg_phases", cfg_phases, 3);
    chk("t3_done_cnt", done_cnt, 1);

    // layer count clamped to MAX_LAYERS
    for (int i = 0; i < 32; i++) tiles_tab[i] = 1;
    run(20, 500, 0);
    chk("t4_cfg_phases", cfg_phases, 8);
    chk("t4_last_cfg_layer", last_cfg_layer, 7);
    chk("t4_ntiles", log_q.size(), 8);
    chk("t4_done_cnt", done_cnt, 1);

    // abort in WAIT on layer 1, tile 2
    tiles_tab[0] = 3;
    tiles_tab[1] = 3;
    run(2, 300, 1);
    chk("t5_aborted", int'(aborted), 1);
    chk("t5_state", post_state, 0);
    chk("t5_busy", post_busy, 0);
    chk("t5_layer_clr", post_layer, 0);
    chk("t5_tile_clr", post_tile, 0);
    chk("t5_no_done", done_cnt, 0);
    tiles_tab[0] = 2;
    run(1, 100, 0);
    chk("t5_restart_cfg", first_cfg_layer, 0);
    chk("t5_restart_n", log_q.size(), 2);
    if (log_q.size() == 2) chk("t5_restart_t0", log_q[0], 0);
    chk("t5_restart_done", done_cnt, 1);

    // spurious strobes, held tile count, reset mid-ISSUE
    @(negedge clk);
    start = 1'b1;
    num_layers = 10'd2;
    @(negedge clk);
    start = 1'b0;
    chk("t6_cfg_state", int'(state), 1);
    cfg_valid = 1'b1;
    cfg_num_tiles = 16'd2;
    @(negedge clk);
    chk("t6_issue_state", int'(state), 2);
    cfg_valid = 1'b0;
    cfg_num_tiles = 16'd9;
    tile_done = 1'b1;
    @(negedge clk);
    chk("t6_td_in_issue", int'(state), 3);
    chk("t6_tile_idx0", int'(tile_idx), 0);
    tile_done = 1'b0;
    start = 1'b1;
    cfg_valid = 1'b1;
    @(negedge clk);
    chk("t6_spur_state", int'(state), 3);
    chk("t6_spur_layer", int'(layer_idx), 0);
    start = 1'b0;
    cfg_valid = 1'b0;
    tile_done = 1'b1;
    @(negedge clk);
    chk("t6_tile_idx1", int'(tile_idx), 1);
    chk("t6_issue2", int'(state), 2);
    tile_done = 1'b0;
    @(negedge clk);
    tile_done = 1'b1;
    @(negedge clk);
    tile_done = 1'b0;
    chk("t6_held_tiles", int'(state), 4);
    @(negedge clk);
    chk("t6_next_cfg", int'(state), 1);
    chk("t6_layer1", int'(layer_idx), 1);
    cfg_valid = 1'b1;
    cfg_num_tiles = 16'd1;
    @(negedge clk);
    cfg_valid = 1'b0;
    chk("t6_issue_l1", int'(state), 2);
    #2;
    reset = 1'b0;
    #1;
    chk("t6_rst_state", int'(state), 0);
    chk("t6_rst_busy", int'(busy), 0);
    chk("t6_rst_ts", int'(tile_start), 0);
    chk("t6_rst_layer", int'(layer_idx), 0);
    chk("t6_rst_done", int'(done), 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("t6_after_rst", int'(state), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
